adam_block_sequencer: RTL and testbench

- Upstream neighbour of the per-drive sector loader in the ADAM disk path.
- Takes 1 KB ADAM block requests from the AdamNet disk-device emulation and splits each into two 512-byte sector transactions on the loader's disk_* interface.
- Read data leaves, and write data enters, as byte streams with valid/ready handshakes.

---
 rtl/adam_disk_pkg.sv | 10 +
 rtl/adam_sector_streamer.sv | 57 +++++
 rtl/adam_block_sequencer.sv | 105 ++++++++++
 tb/tb_adam_block_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adam_disk_pkg.sv
// adam_disk_pkg: shared state encoding and sector geometry for the ADAM disk path
package adam_disk_pkg;
    localparam int SECTOR_BYTES = 512;
    localparam int BLOCK_SECTORS = 2;
    localparam int SADDR_W = $clog2(SECTOR_BYTES);
    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_LOAD, S_RD_ADDR, S_RD_DATA,
        S_WR_FILL, S_FLUSH, S_FWAIT, S_NEXT, S_FIN
    } state_t;
endpackage

// File: rtl/adam_sector_streamer.sv
// adam_sector_streamer: one-sector byte streamer between the block FSM and the loader buffer
module adam_sector_streamer
    import adam_disk_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  state_t             state,
    input  logic [7:0]         disk_data,
    input  logic               rd_ready,
    input  logic               wr_valid,
    input  logic [7:0]         wr_data,
    output logic [SADDR_W-1:0] disk_addr,
    output logic               disk_wr,
    output logic [7:0]         disk_din,
    output logic               rd_valid,
    output logic [7:0]         rd_data,
    output logic               wr_ready,
    output logic               rd_last,
    output logic               wr_last
);
    localparam logic [SADDR_W-1:0] LAST = SADDR_W'(SECTOR_BYTES - 1);
    logic [SADDR_W:0] cnt;
    assign wr_ready = state == S_WR_FILL && !cnt[SADDR_W];
    assign rd_last  = rd_valid && rd_ready && disk_addr == LAST;
    assign wr_last  = disk_wr && disk_addr == LAST;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt       <= '0;
            disk_addr <= '0;
            disk_wr   <= 1'b0;
            disk_din  <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            disk_wr <= wr_valid && wr_ready;
            if (wr_valid && wr_ready) begin
                disk_din  <= wr_data;
                disk_addr <= cnt[SADDR_W-1:0];
                cnt       <= cnt + 1'b1;
            end
            // first RD_DATA cycle captures the RAM output, later ones hold it until accepted
            if (state == S_RD_DATA) begin
                if (!rd_valid) begin
                    rd_valid <= 1'b1;
                    rd_data  <= disk_data;
                end else if (rd_ready) begin
                    rd_valid  <= 1'b0;
                    disk_addr <= disk_addr + 1'b1;
                end
            end
            if (state != S_RD_ADDR && state != S_RD_DATA && state != S_WR_FILL) begin
                disk_addr <= '0;
                cnt       <= '0;
            end
        end
    end
endmodule

// File: rtl/adam_block_sequencer.sv
// adam_block_sequencer: splits 1 KB ADAM block requests into two 512-byte loader sector transactions
module adam_block_sequencer
    import adam_disk_pkg::*;
#(
    parameter int unsigned MAX_BLOCKS   = 160,
    parameter int unsigned LOAD_TIMEOUT = 2**20,
    parameter int unsigned FLUSH_WAIT   = 2048
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               blk_req,
    input  logic               blk_write,
    input  logic [31:0]        blk_num,
    output logic               blk_busy,
    output logic               blk_done,
    output logic               blk_error,
    output logic               rd_valid,
    output logic [7:0]         rd_data,
    input  logic               rd_ready,
    input  logic               wr_valid,
    input  logic [7:0]         wr_data,
    output logic               wr_ready,
    input  logic               disk_present,
    output logic [31:0]        disk_sector,
    output logic               disk_load,
    input  logic               disk_sector_loaded,
    output logic [SADDR_W-1:0] disk_addr,
    output logic               disk_wr,
    output logic               disk_flush,
    input  logic               disk_error,
    output logic [7:0]         disk_din,
    input  logic [7:0]         disk_data
);
    state_t      state;
    logic        wr_q, h, rd_last, wr_last;
    logic [31:0] num, tmr;
    assign blk_busy    = state != S_IDLE;
    assign disk_load   = state == S_LOAD;
    assign disk_flush  = state == S_FLUSH;
    assign disk_sector = {num[30:0], h};
    adam_sector_streamer u_streamer (
        .clk       (clk),
        .reset_n   (reset_n),
        .state     (state),
        .disk_data (disk_data),
        .rd_ready  (rd_ready),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .disk_addr (disk_addr),
        .disk_wr   (disk_wr),
        .disk_din  (disk_din),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_ready  (wr_ready),
        .rd_last   (rd_last),
        .wr_last   (wr_last)
    );
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wr_q      <= 1'b0;
            h         <= 1'b0;
            num       <= '0;
            tmr       <= '0;
            blk_done  <= 1'b0;
            blk_error <= 1'b0;
        end else begin
            blk_done  <= 1'b0;
            blk_error <= 1'b0;
            // one timer serves both the load timeout and the post-flush wait
            tmr <= (state == S_LOAD || state == S_FWAIT) ? tmr + 1'b1 : '0;
            case (state)
                S_IDLE: if (blk_req) begin
                    state <= S_CHECK;
                    wr_q  <= blk_write;
                    num   <= blk_num;
                    h     <= 1'b0;
                end
                S_CHECK: if (!disk_present || num >= MAX_BLOCKS) begin
                    blk_error <= 1'b1;
                    state     <= S_IDLE;
                end else state <= wr_q ? S_WR_FILL : S_LOAD;
                S_LOAD: if (disk_error || tmr == LOAD_TIMEOUT - 1) begin
                    blk_error <= 1'b1;
                    state     <= S_IDLE;
                end else if (disk_sector_loaded) state <= S_RD_ADDR;
                S_RD_ADDR: state <= S_RD_DATA;
                S_RD_DATA: if (rd_valid && rd_ready) state <= rd_last ? S_NEXT : S_RD_ADDR;
                S_WR_FILL: if (wr_last) state <= S_FLUSH;
                S_FLUSH:   state <= S_FWAIT;
                S_FWAIT:   if (tmr == FLUSH_WAIT - 1) state <= S_NEXT;
                S_NEXT: if (h == 1'(BLOCK_SECTORS - 1)) state <= S_FIN;
                else begin
                    h     <= 1'b1;
                    state <= wr_q ? S_WR_FILL : S_LOAD;
                end
                S_FIN: begin
                    blk_done <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adam_block_sequencer.sv
// tb_adam_block_sequencer: randomized bench with a queue-based block model and a loader/RAM model
module tb_adam_block_sequencer;
    localparam int unsigned LT = 64;
    localparam int unsigned FW = 32;
    logic clk = 0, reset_n = 0, blk_req = 0, blk_write = 0;
    logic [31:0] blk_num = 0;
    logic blk_busy, blk_done, blk_error, rd_valid, wr_ready;
    logic [7:0] rd_data;
    logic rd_ready = 0, wr_valid = 0, disk_present = 1, disk_sector_loaded = 0, disk_error = 0;
    logic [7:0] wr_data = 0, disk_data = 0;
    logic [31:0] disk_sector;
    logic disk_load, disk_wr, disk_flush;
    logic [8:0] disk_addr;
    logic [7:0] disk_din;

    adam_block_sequencer #(.MAX_BLOCKS(160), .LOAD_TIMEOUT(LT), .FLUSH_WAIT(FW)) dut (
        .clk(clk), .reset_n(reset_n), .blk_req(blk_req), .blk_write(blk_write), .blk_num(blk_num),
        .blk_busy(blk_busy), .blk_done(blk_done), .blk_error(blk_error),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .disk_present(disk_present), .disk_sector(disk_sector), .disk_load(disk_load),
        .disk_sector_loaded(disk_sector_loaded), .disk_addr(disk_addr), .disk_wr(disk_wr),
        .disk_flush(disk_flush), .disk_error(disk_error), .disk_din(disk_din), .disk_data(disk_data)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, req_cyc = 0;
    int n_done, n_err, n_load, n_flush, n_wr, nrx, n_wrr, wsf, load0, err_cyc, done_cyc, widx = 0;
    int flush_c[2], wrr_c[2];
    logic [31:0] sect_seen[2], fs_seen[2];
    logic [7:0] rx[1024], wdata[1024], prev_data;
    logic err_load, prev_stall = 0, prev_load = 0, prev_wrr = 0;
    logic rr_mode = 0, wr_en = 0, ld_mode = 0;
    logic [7:0] exp_rd[$];
    logic [31:0] exp_sect[$], exp_flush[$];
    logic [48:0] exp_wr[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] s, input int a);
        logic [8:0] a9;
        a9 = 9'(a);
        return a9[7:0] ^ {7'd0, s[0]};
    endfunction

    // RAM behind the loader: data for an address appears one cycle after it is presented
    initial forever begin
        @(posedge clk);
        disk_data <= byte_of(disk_sector, int'(disk_addr));
    end

    initial forever begin
        @(negedge clk);
        if (disk_load) begin
            if (!ld_mode) begin
                repeat ($urandom_range(1, 8)) @(posedge clk);
                #1 disk_sector_loaded = 1;
                @(posedge clk);
                #1 disk_sector_loaded = 0;
            end
            while (disk_load) @(negedge clk);
        end
    end

    initial forever begin
        @(posedge clk);
        #1 rd_ready = rr_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        logic hs;
        forever begin
            @(negedge clk);
            hs = wr_valid && wr_ready;
            @(posedge clk);
            if (hs) widx++;
            #1;
            if (wr_en && widx < 1024) begin
                wr_valid = $urandom_range(0, 3) != 0;
                wr_data  = wdata[widx];
            end else wr_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (blk_done || blk_error) chk("done_err_excl", 64'(blk_done & blk_error), 64'd0);
            if (blk_done) begin n_done++; done_cyc = cyc; end
            if (blk_error) begin n_err++; err_cyc = cyc; err_load = disk_load; end
            if (disk_load && !prev_load) begin
                if (n_load < 2) sect_seen[n_load] = disk_sector;
                if (n_load == 0) load0 = cyc;
                n_load++;
                if (exp_sect.size() == 0) chk("load_unexpected", 64'd1, 64'd0);
                else chk("load_sector", 64'(disk_sector), 64'(exp_sect.pop_front()));
            end
            if (prev_stall) begin
                chk("rd_hold_valid", 64'(rd_valid), 64'd1);
                chk("rd_hold_data", 64'(rd_data), 64'(prev_data));
            end
            if (rd_valid && rd_ready) begin
                if (nrx < 1024) rx[nrx] = rd_data;
                nrx++;
                if (exp_rd.size() == 0) chk("rd_extra", 64'd1, 64'd0);
                else chk("rd_byte", 64'(rd_data), 64'(exp_rd.pop_front()));
            end
            if (disk_wr) begin
                n_wr++;
                wsf++;
                if (exp_wr.size() == 0) chk("wr_extra", 64'd1, 64'd0);
                else chk("wr_beat", 64'({disk_sector, disk_addr, disk_din}), 64'(exp_wr.pop_front()));
            end
            if (disk_flush) begin
                if (n_flush < 2) begin flush_c[n_flush] = cyc; fs_seen[n_flush] = disk_sector; end
                n_flush++;
                chk("flush_bytes", 64'(wsf), 64'd512);
                wsf = 0;
                if (exp_flush.size() == 0) chk("flush_extra", 64'd1, 64'd0);
                else chk("flush_sector", 64'(disk_sector), 64'(exp_flush.pop_front()));
            end
            if (wr_ready && !prev_wrr) begin
                if (n_wrr < 2) wrr_c[n_wrr] = cyc;
                n_wrr++;
            end
        end
        prev_load  = reset_n & disk_load;
        prev_wrr   = reset_n & wr_ready;
        prev_stall = reset_n & rd_valid & !rd_ready;
        prev_data  = rd_data;
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic clr();
        n_done = 0; n_err = 0; n_load = 0; n_flush = 0; n_wr = 0; nrx = 0; n_wrr = 0; wsf = 0;
        load0 = -1; err_cyc = -1; done_cyc = -1; err_load = 1'bx;
    endtask

    task automatic push_read(input logic [31:0] n);
        for (int s = 0; s < 2; s++) begin
            exp_sect.push_back({n[30:0], 1'(s)});
            for (int a = 0; a < 512; a++) exp_rd.push_back(byte_of({n[30:0], 1'(s)}, a));
        end
    endtask

    task automatic push_write(input logic [31:0] n);
        for (int i = 0; i < 1024; i++) exp_wr.push_back({n[30:0], 1'(i / 512), 9'(i % 512), wdata[i]});
        exp_flush.push_back({n[30:0], 1'b0});
        exp_flush.push_back({n[30:0], 1'b1});
    endtask

    task automatic issue(input logic w, input logic [31:0] n);
        @(posedge clk);
        #1 blk_req = 1; blk_write = w; blk_num = n; req_cyc = cyc;
        @(posedge clk);
        #1 blk_req = 0;
    endtask

    task automatic wait_end(input int budget);
        int k = 0;
        while (n_done + n_err == 0 && k < budget) begin @(posedge clk); k++; end
        if (k >= budget) begin
            checks++; errors++;
            $display("FAIL wait_end actual=timeout required=done_or_error");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 64'(blk_busy), 64'd0);
        chk({tag, "_done"}, 64'(blk_done), 64'd0);
        chk({tag, "_err"}, 64'(blk_error), 64'd0);
        chk({tag, "_rdv"}, 64'(rd_valid), 64'd0);
        chk({tag, "_wrr"}, 64'(wr_ready), 64'd0);
        chk({tag, "_load"}, 64'(disk_load), 64'd0);
        chk({tag, "_dwr"}, 64'(disk_wr), 64'd0);
        chk({tag, "_flush"}, 64'(disk_flush), 64'd0);
        chk({tag, "_addr"}, 64'(disk_addr), 64'd0);
        chk({tag, "_sect"}, 64'(disk_sector), 64'd0);
        chk({tag, "_din"}, 64'(disk_din), 64'd0);
    endtask

    task automatic read_block(input string tag, input logic [31:0] n, input logic poke);
        clr();
        push_read(n);
        issue(0, n);
        if (poke) begin
            repeat (200) @(posedge clk);
            #1 blk_req = 1; blk_num = n ^ 32'd1;
            @(posedge clk);
            #1 blk_req = 0;
        end
        wait_end(20000);
        chk({tag, "_done"}, 64'(n_done), 64'd1);
        chk({tag, "_err"}, 64'(n_err), 64'd0);
        chk({tag, "_bytes"}, 64'(nrx), 64'd1024);
        chk({tag, "_left"}, 64'(exp_rd.size()), 64'd0);
        chk({tag, "_loads"}, 64'(n_load), 64'd2);
        chk({tag, "_load_lat"}, 64'(load0 - req_cyc), 64'd2);
        chk({tag, "_sect0"}, 64'(sect_seen[0]), 64'(n * 2));
    endtask

    task automatic write_block(input string tag, input logic [31:0] n);
        clr();
        push_write(n);
        widx = 0;
        wr_en = 1;
        issue(1, n);
        wait_end(20000);
        wr_en = 0;
        chk({tag, "_done"}, 64'(n_done), 64'd1);
        chk({tag, "_err"}, 64'(n_err), 64'd0);
        chk({tag, "_wrs"}, 64'(n_wr), 64'd1024);
        chk({tag, "_flushes"}, 64'(n_flush), 64'd2);
        chk({tag, "_left"}, 64'(exp_wr.size() + exp_flush.size()), 64'd0);
        chk({tag, "_noload"}, 64'(n_load), 64'd0);
        chk({tag, "_wrr_lat"}, 64'(wrr_c[0] - req_cyc), 64'd2);
        chk({tag, "_fwait"}, 64'(wrr_c[1] - flush_c[0]), 64'(FW + 2));
        chk({tag, "_fin_lat"}, 64'(done_cyc - flush_c[1]), 64'(FW + 3));
    endtask

    initial begin
        logic [31:0] n;
        int k;
        repeat (3) @(posedge clk);
        #1 chk_zero("por");
        reset_n = 1;

        read_block("a", 3, 0);
        chk("a_rx0", 64'(rx[0]), 64'h00);
        chk("a_rx255", 64'(rx[255]), 64'hff);
        chk("a_rx512", 64'(rx[512]), 64'h01);
        chk("a_rx513", 64'(rx[513]), 64'h00);
        chk("a_rx1023", 64'(rx[1023]), 64'hfe);
        chk("a_sect1", 64'(sect_seen[1]), 64'd7);

        rr_mode = 1;
        for (int t = 0; t < 2; t++) read_block("b", 32'($urandom_range(0, 159)), 1);

        for (int i = 0; i < 1024; i++) wdata[i] = 8'(i);
        write_block("c", 5);
        chk("c_fs0", 64'(fs_seen[0]), 64'd10);
        chk("c_fs1", 64'(fs_seen[1]), 64'd11);

        for (int i = 0; i < 1024; i++) wdata[i] = 8'($urandom);
        write_block("d", 32'($urandom_range(0, 159)));

        for (int t = 0; t < 4; t++) begin
            clr();
            disk_present = t >= 2 ? 1'b0 : 1'b1;
            n = t == 0 ? 32'd160 : t == 1 ? 32'hffff_ffff : 32'(t);
            issue(1'(t), n);
            wait_end(50);
            chk("e_err", 64'(n_err), 64'd1);
            chk("e_err_lat", 64'(err_cyc - req_cyc), 64'd2);
            chk("e_noload", 64'(n_load + n_wrr), 64'd0);
            chk("e_busy", 64'(blk_busy), 64'd0);
        end
        disk_present = 1;

        ld_mode = 1;
        clr();
        exp_sect.push_back(32'd14);
        issue(0, 7);
        wait_end(int'(LT) + 50);
        chk("f_err", 64'(n_err), 64'd1);
        chk("f_done", 64'(n_done), 64'd0);
        chk("f_timeout", 64'(err_cyc - load0), 64'(LT));
        chk("f_load_drop", 64'(err_load), 64'd0);
        chk("f_load_lat", 64'(load0 - req_cyc), 64'd2);
        ld_mode = 0;

        clr();
        n = 32'($urandom_range(0, 159));
        push_read(n);
        issue(0, n);
        k = 0;
        while (nrx < 300 && k < 20000) begin @(posedge clk); k++; end
        chk("g_reached300", 64'(k < 20000), 64'd1);
        #1 reset_n = 0;
        @(posedge clk);
        #1 chk_zero("mid");
        exp_rd.delete();
        exp_sect.delete();
        clr();
        @(posedge clk);
        #1 reset_n = 1;
        repeat (3) @(posedge clk);
        #1 chk("g_no_stale", 64'(n_done + n_err), 64'd0);
        read_block("g", 32'($urandom_range(0, 159)), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
